fpu_arb: RTL and testbench

FPU_ARB -- requirements
Module: fpu_arb

---
 rtl/fpu_arb_if.sv | 38 +++
 rtl/fpu_arb.sv | 120 ++++++++++++
 tb/tb_fpu_arb.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arb_if.sv
// Bundle of request, FPU-side and response signals for the bfloat16 FPU arbiter.
// The slave modport is the arbiter view; the master modport is the requester/FPU/consumer view.
interface fpu_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [4*NUM_REQ-1:0]  req_op_i;
  logic [16*NUM_REQ-1:0] req_in1_i;
  logic [16*NUM_REQ-1:0] req_in2_i;
  logic [3:0]            fpu_op_o;
  logic [15:0]           fpu_in1_o;
  logic [15:0]           fpu_in2_o;
  logic [15:0]           fpu_out_i;
  logic                  fpu_overflow_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [15:0]           rsp_data_o;
  logic                  rsp_ovf_o;
  logic [IDW-1:0]        rsp_id_o;
  logic                  ovf_clr_i;
  logic                  ovf_sticky_o;

  modport slave (
    input  req_valid_i, req_op_i, req_in1_i, req_in2_i,
    input  fpu_out_i, fpu_overflow_i, rsp_ready_i, ovf_clr_i,
    output req_ready_o, fpu_op_o, fpu_in1_o, fpu_in2_o,
    output rsp_valid_o, rsp_data_o, rsp_ovf_o, rsp_id_o, ovf_sticky_o
  );

  modport master (
    output req_valid_i, req_op_i, req_in1_i, req_in2_i,
    output fpu_out_i, fpu_overflow_i, rsp_ready_i, ovf_clr_i,
    input  req_ready_o, fpu_op_o, fpu_in1_o, fpu_in2_o,
    input  rsp_valid_o, rsp_data_o, rsp_ovf_o, rsp_id_o, ovf_sticky_o
  );
endinterface

// File: rtl/fpu_arb.sv
// Round-robin arbiter sharing one combinational bfloat16 FPU among NUM_REQ requesters.
// Optional sticky overflow flag is enabled by defining FPU_ARB_STICKY_OVF_EN.
module fpu_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input logic     clk_i,
  input logic     rst_ni,
  fpu_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_grant_q, grant_idx, id_q, rsp_id_q;
  logic           grant_valid;
  logic [3:0]     grant_op, op_q;
  logic [15:0]    grant_in1, grant_in2, in1_q, in2_q, rsp_data_q;
  logic           rsp_ovf_q;

  // Round-robin search starting just after the last granted requester.
  always_comb begin : arb_comb
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_op    = '0;
    grant_in1   = '0;
    grant_in2   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(last_grant_q) + 1 + i) % NUM_REQ;
      if (!grant_valid && bus.req_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDW'(cand);
        grant_op    = bus.req_op_i[4*cand +: 4];
        grant_in1   = bus.req_in1_i[16*cand +: 16];
        grant_in2   = bus.req_in2_i[16*cand +: 16];
      end
    end
    if (state_q != IDLE || !rst_ni) begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    bus.req_ready_o = '0;
    if (grant_valid) begin
      bus.req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FPU operands only change on a grant, so the FPU inputs are quiet outside ISSUE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      op_q         <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      id_q         <= '0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        last_grant_q <= grant_idx;
        op_q         <= grant_op;
        in1_q        <= grant_in1;
        in2_q        <= grant_in2;
        id_q         <= grant_idx;
      end
      if (state_q == ISSUE) begin
        rsp_data_q <= bus.fpu_out_i;
        rsp_ovf_q  <= bus.fpu_overflow_i;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign bus.fpu_op_o    = op_q;
  assign bus.fpu_in1_o   = in1_q;
  assign bus.fpu_in2_o   = in2_q;
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_ovf_o   = rsp_ovf_q;
  assign bus.rsp_id_o    = rsp_id_q;

`ifdef FPU_ARB_STICKY_OVF_EN
  logic sticky_q;

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
    end else if (state_q == ISSUE && bus.fpu_overflow_i) begin
      sticky_q <= 1'b1;
    end else if (bus.ovf_clr_i) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.ovf_sticky_o = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr   = bus.ovf_clr_i;
  assign bus.ovf_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_arb.sv
// Self-checking bench for fpu_arb: FPU stub, protocol model and response scoreboard.
module tb_fpu_arb;

  localparam int NUM_REQ = 2;
  localparam int IDW     = 1;

  typedef enum int {M_IDLE, M_ISSUE, M_RESP} mstate_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    data;
    logic           ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  fpu_arb #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int          total = 0;
  int          bad = 0;
  int          resp_count = 0;
  exp_t        sb[$];
  int          id_log[$];
  logic [15:0] last_data = '0;
  logic        last_ovf = 1'b0;
  int          last_id = 0;

  mstate_t        m_state = M_IDLE;
  logic [IDW-1:0] m_last = IDW'(NUM_REQ - 1);
  logic [3:0]     m_op = '0;
  logic [15:0]    m_in1 = '0;
  logic [15:0]    m_in2 = '0;
  logic           m_sticky = 1'b0;

  // Stub FPU: overflow on opcode F, the documented 1.0+2.0 case, otherwise a data-dependent mix.
  function automatic logic [16:0] stubFpu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 4'hF) return {1'b1, 16'h7F80};
    if (op == 4'h1 && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
    return {1'b0, a ^ b ^ {op, op, op, op}};
  endfunction

  assign {bus.fpu_overflow_i, bus.fpu_out_i} = stubFpu(bus.fpu_op_o, bus.fpu_in1_o, bus.fpu_in2_o);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic [3:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    bus.req_valid_i[k]        = v;
    bus.req_op_i[4*k +: 4]    = op;
    bus.req_in1_i[16*k +: 16] = a;
    bus.req_in2_i[16*k +: 16] = b;
  endtask

  task automatic waitGrant(input int k);
    int cyc = 0;
    while (cyc < 50 && bus.req_ready_o[k] !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("grant_seen", 32'(bus.req_ready_o[k]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitRspValid();
    int cyc = 0;
    @(negedge clk);
    while (cyc < 50 && bus.rsp_valid_o !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rsp_valid_seen", 32'(bus.rsp_valid_o), 32'd1);
  endtask

  task automatic waitResponses(input int n);
    int target = resp_count + n;
    int cyc = 0;
    while (resp_count < target && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    checkOutput("resp_count", 32'(resp_count), 32'(target));
  endtask

  // Protocol model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    logic [16:0]        res;
    mstate_t            nxt;
    int                 cand;
    int                 g;
    if (!rst_n) begin
      checkOutput("ready_in_reset", 32'(bus.req_ready_o), 32'd0);
      m_state  = M_IDLE;
      m_last   = IDW'(NUM_REQ - 1);
      m_op     = '0;
      m_in1    = '0;
      m_in2    = '0;
      m_sticky = 1'b0;
      sb.delete();
    end else begin
      checkOutput("fpu_op", 32'(bus.fpu_op_o), 32'(m_op));
      checkOutput("fpu_in1", 32'(bus.fpu_in1_o), 32'(m_in1));
      checkOutput("fpu_in2", 32'(bus.fpu_in2_o), 32'(m_in2));
      checkOutput("sticky", 32'(bus.ovf_sticky_o), 32'(m_sticky));
      checkOutput("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_state == M_RESP));
      exp_ready = '0;
      nxt = m_state;
      res = stubFpu(m_op, m_in1, m_in2);
`ifdef FPU_ARB_STICKY_OVF_EN
      if (m_state == M_ISSUE && res[16]) m_sticky = 1'b1;
      else if (bus.ovf_clr_i) m_sticky = 1'b0;
`endif
      case (m_state)
        M_IDLE: begin
          g = -1;
          for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(m_last) + 1 + i) % NUM_REQ;
            if (g < 0 && bus.req_valid_i[cand]) g = cand;
          end
          if (g >= 0) begin
            exp_ready[g] = 1'b1;
            m_last = IDW'(g);
            m_op   = bus.req_op_i[4*g +: 4];
            m_in1  = bus.req_in1_i[16*g +: 16];
            m_in2  = bus.req_in2_i[16*g +: 16];
            res    = stubFpu(m_op, m_in1, m_in2);
            sb.push_back('{id: IDW'(g), data: res[15:0], ovf: res[16]});
            nxt = M_ISSUE;
          end
        end
        M_ISSUE: nxt = M_RESP;
        default: begin
          if (sb.size() == 0) begin
            checkOutput("rsp_spurious", 32'd1, 32'd0);
          end else begin
            checkOutput("rsp_data", 32'(bus.rsp_data_o), 32'(sb[0].data));
            checkOutput("rsp_ovf", 32'(bus.rsp_ovf_o), 32'(sb[0].ovf));
            checkOutput("rsp_id", 32'(bus.rsp_id_o), 32'(sb[0].id));
            if (bus.rsp_ready_i) begin
              last_data = bus.rsp_data_o;
              last_ovf  = bus.rsp_ovf_o;
              last_id   = int'(bus.rsp_id_o);
              id_log.push_back(last_id);
              void'(sb.pop_front());
              resp_count++;
              nxt = M_IDLE;
            end
          end
        end
      endcase
      checkOutput("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
      m_state = nxt;
    end
  end

  initial begin
    int base;
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    bus.req_in1_i   = '0;
    bus.req_in2_i   = '0;
    bus.rsp_ready_i = 1'b1;
    bus.ovf_clr_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_rsp_data", 32'(bus.rsp_data_o), 32'd0);
    checkOutput("rst_rsp_ovf", 32'(bus.rsp_ovf_o), 32'd0);
    checkOutput("rst_rsp_id", 32'(bus.rsp_id_o), 32'd0);

    // Fairness: both requesters held valid, ids must alternate starting with 0.
    $display("[TB] fairness");
    id_log.delete();
    @(posedge clk);
    #1;
    base = resp_count;
    while (resp_count < base + 8 && resp_count < base + 100) begin
      applyStimulus(0, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      applyStimulus(1, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      @(posedge clk);
      #1;
      if ($time > 20000) break;
    end
    applyStimulus(0, 1'b0, 4'h0, 16'h0, 16'h0);
    applyStimulus(1, 1'b0, 4'h0, 16'h0, 16'h0);
    checkOutput("fair_count", 32'(resp_count - base), 32'd8);
    for (int i = 0; i < 8 && i < id_log.size(); i++) begin
      checkOutput("fair_id", 32'(id_log[i]), 32'(i % 2));
    end

    // Single request with documented operands.
    $display("[TB] single request");
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 4'h1, 16'h3F80, 16'h4000);
    waitGrant(0);
    applyStimulus(0, 1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("single_fpu_op", 32'(bus.fpu_op_o), 32'h1);
    checkOutput("single_fpu_in1", 32'(bus.fpu_in1_o), 32'h3F80);
    checkOutput("single_fpu_in2", 32'(bus.fpu_in2_o), 32'h4000);
    @(negedge clk);
    checkOutput("single_latency", 32'(bus.rsp_valid_o), 32'd1);
    waitResponses(1);
    checkOutput("single_data", 32'(last_data), 32'h4040);
    checkOutput("single_id", 32'(last_id), 32'd0);

    // Backpressure: consumer stalls five cycles while req1 waits.
    $display("[TB] backpressure");
    bus.rsp_ready_i = 1'b0;
    applyStimulus(0, 1'b1, 4'h3, 16'h1111, 16'h2222);
    waitGrant(0);
    applyStimulus(0, 1'b0, 4'h0, 16'h0, 16'h0);
    applyStimulus(1, 1'b1, 4'h5, 16'hABCD, 16'h0F0F);
    waitRspValid();
    base = resp_count;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_no_resp", 32'(resp_count - base), 32'd0);
    bus.rsp_ready_i = 1'b1;
    waitResponses(1);
    waitGrant(1);
    applyStimulus(1, 1'b0, 4'h0, 16'h0, 16'h0);
    waitResponses(1);

    // Overflow and sticky flag.
    $display("[TB] overflow");
    applyStimulus(1, 1'b1, 4'hF, 16'h7F00, 16'h7F00);
    waitGrant(1);
    applyStimulus(1, 1'b0, 4'h0, 16'h0, 16'h0);
    waitResponses(1);
    checkOutput("ovf_flag", 32'(last_ovf), 32'd1);
    checkOutput("ovf_data", 32'(last_data), 32'h7F80);
    @(negedge clk);
`ifdef FPU_ARB_STICKY_OVF_EN
    checkOutput("sticky_set", 32'(bus.ovf_sticky_o), 32'd1);
`else
    checkOutput("sticky_set", 32'(bus.ovf_sticky_o), 32'd0);
`endif
    @(posedge clk);
    #1;
    bus.ovf_clr_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr_i = 1'b0;
    @(negedge clk);
    checkOutput("sticky_clr", 32'(bus.ovf_sticky_o), 32'd0);

    // Reset while the response is pending.
    $display("[TB] reset mid-operation");
    bus.rsp_ready_i = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 4'h2, 16'h4455, 16'h6677);
    waitGrant(0);
    applyStimulus(0, 1'b0, 4'h0, 16'h0, 16'h0);
    waitRspValid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_valid", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("rst_mid_data", 32'(bus.rsp_data_o), 32'd0);
    bus.rsp_ready_i = 1'b1;
    base = resp_count;
    applyStimulus(1, 1'b1, 4'h6, 16'h1357, 16'h2468);
    waitGrant(1);
    applyStimulus(1, 1'b0, 4'h0, 16'h0, 16'h0);
    waitResponses(1);
    checkOutput("rst_mid_id", 32'(last_id), 32'd1);

    // Withdrawal: req1 pulses valid only while req0 is in service.
    $display("[TB] withdrawal");
    applyStimulus(0, 1'b1, 4'h4, 16'h0A0A, 16'h5050);
    waitGrant(0);
    applyStimulus(0, 1'b0, 4'h0, 16'h0, 16'h0);
    applyStimulus(1, 1'b1, 4'h7, 16'hDEAD, 16'hBEEF);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 4'h0, 16'h0, 16'h0);
    base = resp_count;
    waitResponses(1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("wd_resp_count", 32'(resp_count - base), 32'd1);
    checkOutput("wd_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("wd_last_id", 32'(last_id), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
